mem_rr_ctrl: RTL and testbench

MEM_RR_CTRL -- requirements
Module: mem_rr_ctrl

---
 rtl/mem_ctrl_pkg.sv | 17 +
 rtl/mem_rr_ctrl_if.sv | 31 +++
 rtl/rr_arbiter_2.sv | 37 +++
 rtl/mem_rr_ctrl.sv | 110 +++++++++++
 tb/tb_mem_rr_ctrl.sv | 287 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_ctrl_pkg.sv
// Shared definitions for the two-port round-robin memory controller.
//   ADDR_W / DATA_W : default word-address and data widths (16 x 32 memory)
//   NUM_PORTS       : number of requesters sharing the memory
//   state_e         : controller FSM state encoding
package mem_ctrl_pkg;

    localparam int ADDR_W    = 4;
    localparam int DATA_W    = 32;
    localparam int NUM_PORTS = 2;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_ACCESS  = 2'd1,
        S_RD_WAIT = 2'd2
    } state_e;

endpackage

// File: rtl/mem_rr_ctrl_if.sv
// Request/response bundle between the requesters and mem_rr_ctrl.
//   req_valid/req_we/req_addr/req_wdata : per-port request (master drives)
//   req_ready                           : per-port accept strobe (slave drives)
//   rsp_valid                           : per-port completion pulse (slave drives)
//   rsp_rdata                           : shared read-data return (slave drives)
interface mem_rr_ctrl_if #(
    parameter int ADDR_W    = mem_ctrl_pkg::ADDR_W,
    parameter int DATA_W    = mem_ctrl_pkg::DATA_W,
    parameter int NUM_PORTS = mem_ctrl_pkg::NUM_PORTS
);
    import mem_ctrl_pkg::*;

    logic [NUM_PORTS-1:0]             req_valid;
    logic [NUM_PORTS-1:0]             req_ready;
    logic [NUM_PORTS-1:0]             req_we;
    logic [NUM_PORTS-1:0][ADDR_W-1:0] req_addr;
    logic [NUM_PORTS-1:0][DATA_W-1:0] req_wdata;
    logic [NUM_PORTS-1:0]             rsp_valid;
    logic [DATA_W-1:0]                rsp_rdata;

    modport master (
        output req_valid, req_we, req_addr, req_wdata,
        input  req_ready, rsp_valid, rsp_rdata
    );

    modport slave (
        input  req_valid, req_we, req_addr, req_wdata,
        output req_ready, rsp_valid, rsp_rdata
    );

endinterface

// File: rtl/rr_arbiter_2.sv
// Two-way round-robin arbiter.
//   clk, rst : clock and asynchronous active-high reset
//   req      : request vector (already gated by the caller when it cannot accept)
//   accept   : the granted request was taken this cycle; advances the pointer
//   grant    : one-hot combinational grant, zero when nothing is requested
module rr_arbiter_2
    import mem_ctrl_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NUM_PORTS-1:0] req,
    input  logic                 accept,
    output logic [NUM_PORTS-1:0] grant
);

    // 1 = port 1 was granted most recently; reset value makes port 0 win the first tie
    logic last_grant;

    always_comb begin
        grant = '0;
        case (req)
            2'b01:   grant = 2'b01;
            2'b10:   grant = 2'b10;
            2'b11:   grant = last_grant ? 2'b01 : 2'b10;
            default: grant = '0;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_grant <= 1'b1;
        end else if (accept) begin
            last_grant <= grant[1];
        end
    end

endmodule

// File: rtl/mem_rr_ctrl.sv
// Round-robin controller sharing one synchronous single-port memory between two
// requesters. One operation in flight at a time.
//   clk, rst          : clock and asynchronous active-high reset
//   bus (slave)       : request/response bundle, see mem_rr_ctrl_if
//   mem_d_in/mem_addr : write data and word address to the memory
//   mem_en_wr/rd      : one-cycle write / read strobes
//   mem_d_out         : memory read data, valid the cycle after mem_en_rd
//   busy              : controller not idle
//
//   state     | meaning
//   ----------+---------------------------------------------------------
//   S_IDLE    | waiting; arbiter may grant and accept one request
//   S_ACCESS  | memory strobe for the latched op is driven this cycle
//   S_RD_WAIT | memory returns read data; captured into rsp_rdata
module mem_rr_ctrl #(
    parameter int ADDR_W = mem_ctrl_pkg::ADDR_W,
    parameter int DATA_W = mem_ctrl_pkg::DATA_W
) (
    input  logic              clk,
    input  logic              rst,
    mem_rr_ctrl_if.slave      bus,
    output logic [DATA_W-1:0] mem_d_in,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_en_wr,
    output logic              mem_en_rd,
    input  logic [DATA_W-1:0] mem_d_out,
    output logic              busy
);
    import mem_ctrl_pkg::*;

    state_e                 state;
    logic                   idle;
    logic [NUM_PORTS-1:0]   arb_req;
    logic [NUM_PORTS-1:0]   grant;
    logic                   accept;
    logic                   sel;

    logic                   op_we;
    logic                   op_port;
    logic [ADDR_W-1:0]      op_addr;
    logic [DATA_W-1:0]      op_wdata;
    logic [NUM_PORTS-1:0]   op_onehot;

    assign idle    = (state == S_IDLE);
    // Only offer requests to the arbiter when a new op can actually be taken.
    assign arb_req = idle ? bus.req_valid : '0;
    assign accept  = |(bus.req_valid & grant);
    assign sel     = grant[1];

    rr_arbiter_2 u_arb (
        .clk    (clk),
        .rst    (rst),
        .req    (arb_req),
        .accept (accept),
        .grant  (grant)
    );

    assign bus.req_ready = grant;

    always_comb begin
        op_onehot          = '0;
        op_onehot[op_port] = 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= S_IDLE;
            op_we         <= 1'b0;
            op_port       <= 1'b0;
            op_addr       <= '0;
            op_wdata      <= '0;
            bus.rsp_valid <= '0;
            bus.rsp_rdata <= '0;
        end else begin
            bus.rsp_valid <= '0;
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        state    <= S_ACCESS;
                        op_we    <= bus.req_we[sel];
                        op_port  <= sel;
                        op_addr  <= bus.req_addr[sel];
                        op_wdata <= bus.req_wdata[sel];
                    end
                end
                S_ACCESS: begin
                    if (op_we) begin
                        state         <= S_IDLE;
                        bus.rsp_valid <= op_onehot;
                    end else begin
                        state <= S_RD_WAIT;
                    end
                end
                S_RD_WAIT: begin
                    state         <= S_IDLE;
                    bus.rsp_valid <= op_onehot;
                    bus.rsp_rdata <= mem_d_out;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign mem_addr  = op_addr;
    assign mem_d_in  = op_wdata;
    assign mem_en_wr = (state == S_ACCESS) &&  op_we;
    assign mem_en_rd = (state == S_ACCESS) && !op_we;
    assign busy      = !idle;

endmodule

// File: tb/tb_mem_rr_ctrl.sv
module tb_mem_rr_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] mem_d_in;
    logic [3:0]  mem_addr;
    logic        mem_en_wr, mem_en_rd, busy;
    logic [31:0] mem_d_out = '0;

    mem_rr_ctrl_if #(.ADDR_W(4), .DATA_W(32)) bus ();

    mem_rr_ctrl #(.ADDR_W(4), .DATA_W(32)) dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus),
        .mem_d_in  (mem_d_in),
        .mem_addr  (mem_addr),
        .mem_en_wr (mem_en_wr),
        .mem_en_rd (mem_en_rd),
        .mem_d_out (mem_d_out),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Memory the controller drives: synchronous write, registered read.
    logic [31:0] mem [16] = '{default: 32'h0};
    always @(posedge clk) begin
        if (mem_en_wr) mem[mem_addr] <= mem_d_in;
        if (mem_en_rd) mem_d_out <= mem[mem_addr];
    end

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ---------------- behavioural reference ----------------
    // Each accepted op is a record with its accept cycle; everything the
    // controller shows on a given cycle follows from the op timeline:
    // strobe at acc+1, response at acc+2 (write) or acc+3 (read), and no new
    // accept while an op is between acceptance and its response cycle.
    typedef struct {
        int          acc;
        int          port;
        bit          we;
        logic [3:0]  addr;
        logic [31:0] data;
    } op_t;

    op_t         q[$];
    logic [31:0] ref_mem [16] = '{default: 32'h0};
    int          last_g  = 1;
    logic [31:0] last_rd = '0;

    always @(negedge clk) begin : model
        logic [1:0]  e_rsp, e_rdy;
        logic        e_wr, e_rd, e_busy, e_mem;
        logic [3:0]  e_addr;
        logic [31:0] e_din;
        int          g, d;
        op_t         n;
        if (rst) begin
            q.delete();
            last_g  = 1;
            last_rd = '0;
        end else begin
            e_rsp = '0; e_rdy = '0; e_wr = 0; e_rd = 0; e_busy = 0; e_mem = 0;
            e_addr = '0; e_din = '0;
            foreach (q[k]) begin
                d = q[k].we ? 2 : 3;
                if (cyc == q[k].acc + 1) begin
                    e_wr = q[k].we; e_rd = !q[k].we; e_mem = 1;
                    e_addr = q[k].addr; e_din = q[k].data;
                end
                if (cyc > q[k].acc && cyc < q[k].acc + d) e_busy = 1;
                if (cyc == q[k].acc + d) begin
                    e_rsp[q[k].port] = 1'b1;
                    if (!q[k].we) last_rd = q[k].data;
                end
            end
            while (q.size() > 0 && cyc >= q[0].acc + (q[0].we ? 2 : 3)) void'(q.pop_front());
            if (!e_busy) begin
                if (bus.req_valid == 2'b11) g = (last_g == 1) ? 0 : 1;
                else if (bus.req_valid[0])  g = 0;
                else if (bus.req_valid[1])  g = 1;
                else                        g = -1;
                if (g >= 0) begin
                    e_rdy[g] = 1'b1;
                    last_g   = g;
                    n.acc = cyc; n.port = g; n.we = bus.req_we[g]; n.addr = bus.req_addr[g];
                    if (n.we) begin
                        n.data = bus.req_wdata[g];
                        ref_mem[n.addr] = n.data;
                    end else begin
                        n.data = ref_mem[n.addr];
                    end
                    q.push_back(n);
                end
            end
            check("req_ready", bus.req_ready, e_rdy);
            check("rsp_valid", bus.rsp_valid, e_rsp);
            check("rsp_rdata", bus.rsp_rdata, last_rd);
            check("busy", busy, e_busy);
            check("mem_en_wr", mem_en_wr, e_wr);
            check("mem_en_rd", mem_en_rd, e_rd);
            if (e_mem) begin
                check("mem_addr", mem_addr, e_addr);
                if (e_wr) check("mem_d_in", mem_d_in, e_din);
            end
        end
    end

    // ---------------- directed helpers ----------------
    task automatic issue(input int p, input bit we, input logic [3:0] a, input logic [31:0] dat,
                         output int lat_en, output int lat_rsp, output logic [1:0] rsp_bits,
                         output logic [31:0] rdata, output logic en_wr);
        int acc;
        bit got;
        got = 0; acc = 0; lat_en = -1; lat_rsp = -1; rsp_bits = '0; rdata = '0; en_wr = 0;
        @(posedge clk); #1;
        bus.req_valid[p] = 1'b1; bus.req_we[p] = we; bus.req_addr[p] = a; bus.req_wdata[p] = dat;
        for (int k = 0; k < 20 && !got; k++) begin
            @(negedge clk);
            if (bus.req_ready[p]) begin got = 1; acc = cyc; end
        end
        check("accept within budget", got, 1);
        @(posedge clk); #1;
        bus.req_valid[p] = 1'b0;
        for (int k = 0; k < 6 && lat_rsp < 0; k++) begin
            @(negedge clk);
            if ((mem_en_wr || mem_en_rd) && lat_en < 0) begin lat_en = cyc - acc; en_wr = mem_en_wr; end
            if (bus.rsp_valid != 2'b00) begin lat_rsp = cyc - acc; rsp_bits = bus.rsp_valid; rdata = bus.rsp_rdata; end
        end
    endtask

    int          le, lr, ng, n_en, n_r0, n_r1;
    logic [1:0]  rb, acc_v;
    logic [31:0] rd;
    logic        ew;
    bit          got;
    int          gseq [4];

    initial begin
        bus.req_valid = '0; bus.req_we = '0; bus.req_addr = '0; bus.req_wdata = '0;
        #1;
        check("reset busy", busy, 0);
        check("reset rsp_valid", bus.rsp_valid, 0);
        check("reset rsp_rdata", bus.rsp_rdata, 0);
        check("reset mem_en", {mem_en_wr, mem_en_rd}, 0);
        check("reset mem_addr", mem_addr, 0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        // single write then read
        issue(0, 1, 4'd3, 32'hDEADBEEF, le, lr, rb, rd, ew);
        check("wr strobe latency", le, 1);
        check("wr strobe is write", ew, 1);
        check("wr rsp latency", lr, 2);
        check("wr rsp port", rb, 2'b01);
        issue(0, 0, 4'd3, 32'h0, le, lr, rb, rd, ew);
        check("rd strobe is read", ew, 0);
        check("rd rsp latency", lr, 3);
        check("rd data addr3", rd, 32'hDEADBEEF);

        // boundary addresses
        issue(1, 1, 4'd15, 32'hFFFFFFFF, le, lr, rb, rd, ew);
        issue(1, 1, 4'd0, 32'h00000000, le, lr, rb, rd, ew);
        issue(1, 0, 4'd0, 32'h0, le, lr, rb, rd, ew);
        check("rd data addr0", rd, 32'h00000000);
        check("rd rsp port1", rb, 2'b10);
        issue(1, 0, 4'd15, 32'h0, le, lr, rb, rd, ew);
        check("rd data addr15", rd, 32'hFFFFFFFF);
        issue(0, 1, 4'd7, 32'h77770007, le, lr, rb, rd, ew);
        check("rdata held over write", rd, 32'hFFFFFFFF);

        // reset while in RD_WAIT
        @(posedge clk); #1;
        bus.req_valid[0] = 1'b1; bus.req_we[0] = 1'b0; bus.req_addr[0] = 4'd3; bus.req_wdata[0] = 32'hA5A5A5A5;
        got = 0;
        for (int k = 0; k < 10 && !got; k++) begin @(negedge clk); got = bus.req_ready[0]; end
        check("rst test accept", got, 1);
        @(posedge clk); #1 bus.req_valid[0] = 1'b0;
        @(posedge clk); #2;
        check("busy in RD_WAIT", busy, 1);
        check("addr before rst", mem_addr, 4'd3);
        rst = 1'b1;
        #1;
        check("rst busy", busy, 0);
        check("rst rsp_valid", bus.rsp_valid, 0);
        check("rst rsp_rdata", bus.rsp_rdata, 0);
        check("rst mem_en", {mem_en_wr, mem_en_rd}, 0);
        check("rst mem_addr", mem_addr, 0);
        check("rst mem_d_in", mem_d_in, 0);
        @(posedge clk); #1 rst = 1'b0;
        n_r0 = 0;
        for (int k = 0; k < 4; k++) begin @(negedge clk); n_r0 += int'(bus.rsp_valid != 0); end
        check("no rsp after rst", n_r0, 0);
        issue(1, 0, 4'd7, 32'h0, le, lr, rb, rd, ew);
        check("post-rst rd data", rd, 32'h77770007);
        check("post-rst rd port", rb, 2'b10);

        // port1 withdraws valid while busy
        @(posedge clk); #1;
        bus.req_valid[0] = 1'b1; bus.req_we[0] = 1'b0; bus.req_addr[0] = 4'd15;
        got = 0;
        for (int k = 0; k < 10 && !got; k++) begin @(negedge clk); got = bus.req_ready[0]; end
        check("withdraw test accept", got, 1);
        @(posedge clk); #1;
        bus.req_valid[0] = 1'b0;
        bus.req_valid[1] = 1'b1; bus.req_we[1] = 1'b1; bus.req_addr[1] = 4'd9; bus.req_wdata[1] = 32'h12345678;
        n_en = 0; n_r0 = 0; n_r1 = 0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            n_en += int'(mem_en_wr) + int'(mem_en_rd);
            n_r0 += int'(bus.rsp_valid[0]);
            n_r1 += int'(bus.rsp_valid[1]);
            if (k == 1) begin #1 bus.req_valid[1] = 1'b0; end
        end
        check("withdraw enables", n_en, 1);
        check("withdraw rsp port0", n_r0, 1);
        check("withdraw rsp port1", n_r1, 0);

        // simultaneous held requests from reset alternate 0,1,0,1
        @(posedge clk); #1 rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        bus.req_we = 2'b11;
        bus.req_addr[0] = 4'd5; bus.req_wdata[0] = 32'h55;
        bus.req_addr[1] = 4'd6; bus.req_wdata[1] = 32'h66;
        bus.req_valid = 2'b11;
        ng = 0;
        for (int k = 0; k < 4; k++) gseq[k] = -1;
        for (int k = 0; k < 40 && ng < 4; k++) begin
            @(negedge clk);
            if (bus.req_ready[0])      begin gseq[ng] = 0; ng++; end
            else if (bus.req_ready[1]) begin gseq[ng] = 1; ng++; end
        end
        @(posedge clk); #1 bus.req_valid = '0;
        check("rr grant count", ng, 4);
        check("rr grant 0", gseq[0], 0);
        check("rr grant 1", gseq[1], 1);
        check("rr grant 2", gseq[2], 0);
        check("rr grant 3", gseq[3], 1);
        repeat (3) @(posedge clk);

        // back-to-back alternating reads
        for (int k = 0; k < 8; k++) begin
            issue(k % 2, 0, 4'(k * 2), 32'h0, le, lr, rb, rd, ew);
            check("b2b rsp latency", lr, 3);
            check("b2b rsp port", rb, (k % 2 == 0) ? 2'b01 : 2'b10);
        end

        // random traffic against the model
        acc_v = '0;
        repeat (3000) begin
            @(negedge clk);
            acc_v = bus.req_valid & bus.req_ready;
            @(posedge clk); #1;
            for (int i = 0; i < 2; i++) begin
                if (bus.req_valid[i] && !acc_v[i]) begin
                    if ($urandom_range(0, 9) == 0) bus.req_valid[i] = 1'b0;
                end else begin
                    bus.req_valid[i] = ($urandom_range(0, 9) < 5);
                    bus.req_we[i]    = 1'($urandom_range(0, 1));
                    bus.req_addr[i]  = 4'($urandom_range(0, 15));
                    bus.req_wdata[i] = $urandom;
                end
            end
        end
        bus.req_valid = '0;
        repeat (8) @(posedge clk);
        @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
